// File: rtl/msrh_lsu_pipe_arb.sv
// msrh_lsu_pipe_arb: per-LSU-pipe EX0 issue arbiter.
// Arbitrates between new scheduler issues and LDQ replays. Replays win by
// default, and a starvation counter forces a scheduler grant after
// STARVE_MAX consecutive losses. The winner is registered into EX0.
module msrh_lsu_pipe_arb #(
    parameter int ISSUE_W    = 128,
    parameter int LDQ_SIZE   = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_iss_valid,
    input  logic [ISSUE_W-1:0]  i_iss_payload,
    output logic                o_iss_ready,
    input  logic                i_replay_valid,
    input  logic [ISSUE_W-1:0]  i_replay_payload,
    input  logic [LDQ_SIZE-1:0] i_replay_index_oh,
    output logic                o_replay_ready,
    input  logic                i_pipe_stall,
    input  logic                i_flush,
    output logic                o_ex0_valid,
    output logic [ISSUE_W-1:0]  o_ex0_payload,
    output logic                o_ex0_is_replay,
    output logic [LDQ_SIZE-1:0] o_ex0_replay_index_oh,
    output logic                o_starve_force
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    logic [0:0]          state;
    logic [0:0]          state_n;
    logic [3:0]          starve_cnt;
    logic [3:0]          starve_cnt_n;
    logic [3:0]          starve_cnt_inc;
    logic                can_grant;
    logic                iss_grant;
    logic                replay_grant;

    logic                ex0_valid;
    logic [ISSUE_W-1:0]  ex0_payload;
    logic                ex0_is_replay;
    logic [LDQ_SIZE-1:0] ex0_replay_index_oh;

    // Grant selection: replay priority in NORMAL, scheduler priority in FORCE.
    always_comb begin
        can_grant    = !i_pipe_stall && !i_flush;
        iss_grant    = 1'b0;
        replay_grant = 1'b0;
        if (state == ST_FORCE) begin
            iss_grant    = can_grant && i_iss_valid;
            replay_grant = can_grant && i_replay_valid && !i_iss_valid;
        end else begin
            replay_grant = can_grant && i_replay_valid;
            iss_grant    = can_grant && i_iss_valid && !i_replay_valid;
        end
    end

    // Starvation counter and next-state logic; stalls leave both untouched.
    always_comb begin
        state_n        = state;
        starve_cnt_n   = starve_cnt;
        starve_cnt_inc = starve_cnt + 4'd1;
        if (i_flush) begin
            state_n      = ST_NORMAL;
            starve_cnt_n = '0;
        end else if (state == ST_NORMAL) begin
            if (can_grant && i_iss_valid && i_replay_valid) begin
                if (starve_cnt_inc == STARVE_LIM) begin
                    starve_cnt_n = '0;
                    state_n      = ST_FORCE;
                end else begin
                    starve_cnt_n = starve_cnt_inc;
                end
            end else if (iss_grant) begin
                starve_cnt_n = '0;
            end
        end else begin
            if (iss_grant) begin
                state_n      = ST_NORMAL;
                starve_cnt_n = '0;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    // EX0 pipeline register: flush kills, stall holds, grant loads.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex0_valid           <= 1'b0;
            ex0_payload         <= '0;
            ex0_is_replay       <= 1'b0;
            ex0_replay_index_oh <= '0;
        end else if (i_flush) begin
            ex0_valid <= 1'b0;
        end else if (i_pipe_stall) begin
            ex0_valid <= ex0_valid;
        end else if (replay_grant) begin
            ex0_valid           <= 1'b1;
            ex0_payload         <= i_replay_payload;
            ex0_is_replay       <= 1'b1;
            ex0_replay_index_oh <= i_replay_index_oh;
        end else if (iss_grant) begin
            ex0_valid           <= 1'b1;
            ex0_payload         <= i_iss_payload;
            ex0_is_replay       <= 1'b0;
            ex0_replay_index_oh <= '0;
        end else begin
            ex0_valid <= 1'b0;
        end
    end

    assign o_iss_ready           = iss_grant;
    assign o_replay_ready        = replay_grant;
    assign o_ex0_valid           = ex0_valid;
    assign o_ex0_payload         = ex0_payload;
    assign o_ex0_is_replay       = ex0_is_replay;
    assign o_ex0_replay_index_oh = ex0_replay_index_oh;
    assign o_starve_force        = (state == ST_FORCE);

`ifdef SIMULATION
    // Protocol sanity checks on requester inputs and grant exclusivity.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_replay_valid && !$onehot(i_replay_index_oh))
            $fatal(1, "msrh_lsu_pipe_arb: replay index is not one-hot");
        if (i_reset_n && iss_grant && replay_grant)
            $fatal(1, "msrh_lsu_pipe_arb: both grants asserted");
    end
`endif

endmodule

// File: tb/tb_msrh_lsu_pipe_arb.sv
// Directed bench for msrh_lsu_pipe_arb with an EX0 scoreboard.
module tb_msrh_lsu_pipe_arb;

    logic         clk;
    logic         rst_n;
    logic         iss_valid;
    logic [127:0] iss_payload;
    logic         iss_ready;
    logic         replay_valid;
    logic [127:0] replay_payload;
    logic [7:0]   replay_index_oh;
    logic         replay_ready;
    logic         pipe_stall;
    logic         flush;
    logic         ex0_valid;
    logic [127:0] ex0_payload;
    logic         ex0_is_replay;
    logic [7:0]   ex0_replay_index_oh;
    logic         starve_force;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic         v;
        logic [127:0] p;
        logic         isr;
        logic [7:0]   oh;
    } ex0_exp_t;

    ex0_exp_t exp_q[$];

    msrh_lsu_pipe_arb #(
        .ISSUE_W(128),
        .LDQ_SIZE(8),
        .STARVE_MAX(4)
    ) dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_iss_valid           (iss_valid),
        .i_iss_payload         (iss_payload),
        .o_iss_ready           (iss_ready),
        .i_replay_valid        (replay_valid),
        .i_replay_payload      (replay_payload),
        .i_replay_index_oh     (replay_index_oh),
        .o_replay_ready        (replay_ready),
        .i_pipe_stall          (pipe_stall),
        .i_flush               (flush),
        .o_ex0_valid           (ex0_valid),
        .o_ex0_payload         (ex0_payload),
        .o_ex0_is_replay       (ex0_is_replay),
        .o_ex0_replay_index_oh (ex0_replay_index_oh),
        .o_starve_force        (starve_force)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected EX0 entry per clock and compares.
    initial begin
        ex0_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex0_valid", 128'(ex0_valid), 128'(e.v));
                if (e.v) begin
                    chk("ex0_payload", ex0_payload, e.p);
                    chk("ex0_is_replay", 128'(ex0_is_replay), 128'(e.isr));
                    chk("ex0_index_oh", 128'(ex0_replay_index_oh), 128'(e.oh));
                end
            end else if (ex0_valid === 1'b1) begin
                tests_failed++;
                $display("FAIL ex0_unexpected: got valid=1 expected no entry at %0t", $time);
            end
        end
    end

    // Drive one cycle of inputs, check grants/force, queue the EX0 result.
    task automatic step(input logic iv, input logic [127:0] ip,
                        input logic rv, input logic [127:0] rp, input logic [7:0] roh,
                        input logic st, input logic fl,
                        input logic e_ir, input logic e_rr, input logic e_force,
                        input logic e_v, input logic [127:0] e_p,
                        input logic e_isr, input logic [7:0] e_oh);
        ex0_exp_t e;
        @(negedge clk);
        iss_valid       = iv;
        iss_payload     = ip;
        replay_valid    = rv;
        replay_payload  = rp;
        replay_index_oh = roh;
        pipe_stall      = st;
        flush           = fl;
        e.v   = e_v;
        e.p   = e_p;
        e.isr = e_isr;
        e.oh  = e_oh;
        exp_q.push_back(e);
        #1;
        chk("iss_ready", 128'(iss_ready), 128'(e_ir));
        chk("replay_ready", 128'(replay_ready), 128'(e_rr));
        chk("starve_force", 128'(starve_force), 128'(e_force));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex0_valid"}, 128'(ex0_valid), 128'(0));
        chk({tag, "_ex0_payload"}, ex0_payload, 128'(0));
        chk({tag, "_ex0_is_replay"}, 128'(ex0_is_replay), 128'(0));
        chk({tag, "_ex0_index_oh"}, 128'(ex0_replay_index_oh), 128'(0));
        chk({tag, "_starve_force"}, 128'(starve_force), 128'(0));
        chk({tag, "_iss_ready"}, 128'(iss_ready), 128'(0));
        chk({tag, "_replay_ready"}, 128'(replay_ready), 128'(0));
    endtask

    initial begin
        int waited;
        rst_n           = 1'b0;
        iss_valid       = 1'b0;
        iss_payload     = '0;
        replay_valid    = 1'b0;
        replay_payload  = '0;
        replay_index_oh = '0;
        pipe_stall      = 1'b0;
        flush           = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scheduler alone for three cycles.
        for (int k = 0; k < 3; k++)
            step(1, 128'h11 + 128'(k), 0, '0, 8'h00, 0, 0,
                 1, 0, 0, 1, 128'h11 + 128'(k), 0, 8'h00);
        step(0, '0, 0, '0, 8'h00, 0, 0, 0, 0, 0, 0, '0, 0, 8'h00);

        // Replay alone.
        step(0, '0, 1, 128'h77, 8'h04, 0, 0, 0, 1, 0, 1, 128'h77, 1, 8'h04);
        step(0, '0, 0, '0, 8'h00, 0, 0, 0, 0, 0, 0, '0, 0, 8'h00);

        // Both valid continuously: four replays then a forced scheduler grant.
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4)
                step(1, 128'h100 + 128'(k), 1, 128'h200 + 128'(k), 8'h10, 0, 0,
                     1, 0, 1, 1, 128'h100 + 128'(k), 0, 8'h00);
            else
                step(1, 128'h100 + 128'(k), 1, 128'h200 + 128'(k), 8'h10, 0, 0,
                     0, 1, 0, 1, 128'h200 + 128'(k), 1, 8'h10);
        end

        // Stall with EX0 holding 0xA5; counter must not advance during stall.
        step(1, 128'h300, 1, 128'hA5, 8'h01, 0, 0, 0, 1, 0, 1, 128'hA5, 1, 8'h01);
        for (int k = 0; k < 2; k++)
            step(1, 128'h300, 1, 128'h301, 8'h01, 1, 0, 0, 0, 0, 1, 128'hA5, 1, 8'h01);
        for (int k = 0; k < 3; k++)
            step(1, 128'h300, 1, 128'h310 + 128'(k), 8'h02, 0, 0,
                 0, 1, 0, 1, 128'h310 + 128'(k), 1, 8'h02);
        step(1, 128'h300, 1, 128'h320, 8'h02, 0, 0, 1, 0, 1, 1, 128'h300, 0, 8'h00);

        // Enter FORCE, then scheduler drops: replay granted, FORCE retained.
        for (int k = 0; k < 4; k++)
            step(1, 128'h400, 1, 128'h410 + 128'(k), 8'h08, 0, 0,
                 0, 1, 0, 1, 128'h410 + 128'(k), 1, 8'h08);
        step(0, '0, 1, 128'h420, 8'h08, 0, 0, 0, 1, 1, 1, 128'h420, 1, 8'h08);

        // Flush with stall in FORCE: no grant, EX0 killed, back to NORMAL.
        step(1, 128'h400, 1, 128'h421, 8'h08, 1, 1, 0, 0, 1, 0, '0, 0, 8'h00);
        for (int k = 0; k < 4; k++)
            step(1, 128'h400, 1, 128'h430 + 128'(k), 8'h08, 0, 0,
                 0, 1, 0, 1, 128'h430 + 128'(k), 1, 8'h08);
        step(1, 128'h400, 1, 128'h440, 8'h08, 0, 0, 1, 0, 1, 1, 128'h400, 0, 8'h00);

        // Asynchronous reset mid-cycle with EX0 valid.
        step(1, 128'h500, 0, '0, 8'h00, 0, 0, 1, 0, 0, 1, 128'h500, 0, 8'h00);
        @(posedge clk);
        #3;
        iss_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, 0, '0, 8'h00, 0, 0, 0, 0, 0, 0, '0, 0, 8'h00);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
